// File: rtl/inv_sub_bytes_iter_if.sv
// Handshake and state buses of the iterative inverse-SubBytes engine.
// The slave modport is the engine's view of the bus and the master modport is the upstream/downstream view.
interface inv_sub_bytes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_sub_bytes_iter.sv
// Purpose: applies the AES InvSbox to all 16 bytes of a state, substituting LANES bytes per cycle.
// Latency: out_valid rises 16/LANES cycles after the accept edge, and one block is in flight at a time.
// Backpressure: the result is held in DONE until out_ready is high, and in_ready is high only in IDLE.
module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    inv_sub_bytes_iter_if.slave        io
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   out_state_q, out_state_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Undo the forward affine map first, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    always_comb begin
        int base;
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_state_d = out_state_q;
        base        = int'(cnt_q) * LANES;
        unique case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    work_d  = io.in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    work_d[(base + l)*8 +: 8] = inv_sbox(work_q[(base + l)*8 +: 8]);
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_state_d = work_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_state_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_state_q <= out_state_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    assign io.busy      = (state_q != IDLE);
    assign io.out_state = out_state_q;
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: a scoreboard checks the LANES=4 engine against a table-based model,
// and four extra instances replay the row-0 vector for the other lane counts.
module tb_inv_sub_bytes_iter;
    localparam logic [127:0] ROW0_IN  = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] ROW0_OUT = 128'hFBD7F3819EA340BF38A53630D56A0952;
    localparam logic [127:0] RT_IN    = 128'h636363637C7C7C7CEDEDEDED16161616;
    localparam logic [127:0] RT_OUT   = 128'h000000000101010153535353FFFFFFFF;

    logic clk;
    logic rst;
    logic sweep_go;
    int   n_checks;
    int   n_pass;

    logic [7:0]   fsb [256];
    logic [7:0]   isb [256];
    logic [127:0] sb_q [$];

    inv_sub_bytes_iter_if dut_if();

    inv_sub_bytes_iter #(.LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (dut_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carry-less product reduced by long division modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--) if (prod[k]) prod = prod ^ (16'h011B << (k - 8));
        return prod[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            fsb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = isb[d[i*8 +: 8]];
        return r;
    endfunction

    // Scoreboard monitor: a handshake is due on the next rising edge.
    always @(negedge clk) begin
        if (!rst && dut_if.out_valid && dut_if.out_ready) begin
            if (sb_q.size() == 0) chk("unexpected_output", dut_if.out_state, 128'hx);
            else chk("out_state", dut_if.out_state, sb_q.pop_front());
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!dut_if.in_ready && k < 50) begin tick(); k++; end
        if (k == 50) chk("in_ready_timeout", 128'(k), 128'(0));
    endtask

    task automatic finish_block(input int hold);
        int lat;
        int k;
        lat = 0;
        while (!dut_if.out_valid && lat < 100) begin tick(); lat++; end
        chk("latency", 128'(lat), 128'(4));
        dut_if.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) tick();
        dut_if.out_ready = 1'b1;
        k = 0;
        while (dut_if.out_valid && k < 50) begin tick(); k++; end
        if (k == 50) chk("handoff_timeout", 128'(k), 128'(0));
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] exp, input int hold);
        wait_ready();
        dut_if.in_valid = 1'b1;
        dut_if.in_state = d;
        tick();
        dut_if.in_valid = 1'b0;
        sb_q.push_back(exp);
        finish_block(hold);
    endtask

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sw
            localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
            logic done;
            int   lat;
            inv_sub_bytes_iter_if sif();
            inv_sub_bytes_iter #(.LANES(L)) dut_sw (
                .clk (clk),
                .rst (rst),
                .io  (sif.slave)
            );
            initial begin
                done          = 1'b0;
                sif.in_valid  = 1'b0;
                sif.in_state  = '0;
                sif.out_ready = 1'b1;
                wait (sweep_go);
                tick();
                sif.in_valid = 1'b1;
                sif.in_state = ROW0_IN;
                tick();
                sif.in_valid = 1'b0;
                lat = 0;
                while (!sif.out_valid && lat < 40) begin tick(); lat++; end
                chk($sformatf("sweep_latency_L%0d", L), 128'(lat), 128'(16 / L));
                chk($sformatf("sweep_state_L%0d", L), sif.out_state, ROW0_OUT);
                tick();
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        logic [127:0] snap;
        int k;
        n_checks = 0;
        n_pass   = 0;
        sweep_go = 1'b0;
        rst      = 1'b1;
        dut_if.in_valid  = 1'b1;
        dut_if.in_state  = ROW0_IN;
        dut_if.out_ready = 1'b1;
        build_tables();

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_busy", 128'(dut_if.busy), 128'(0));
        end
        rst = 1'b0;
        dut_if.in_valid = 1'b0;
        #1;
        chk("reset_in_ready", 128'(dut_if.in_ready), 128'(1));
        chk("reset_out_valid", 128'(dut_if.out_valid), 128'(0));
        chk("reset_out_state", dut_if.out_state, 128'h0);
        tick();
        chk("idle_busy", 128'(dut_if.busy), 128'(0));

        send(ROW0_IN, ROW0_OUT, 0);
        send(RT_IN, RT_OUT, 1);

        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) begin
                d[i*8 +: 8] = fsb[b*16 + i];
                e[i*8 +: 8] = 8'(b*16 + i);
            end
            send(d, e, 0);
        end

        for (int b = 0; b < 20; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(d, model(d), int'($urandom_range(0, 3)));
        end

        // Backpressure: hold the result while a second word waits upstream.
        wait_ready();
        d = {$urandom, $urandom, $urandom, $urandom};
        dut_if.in_valid = 1'b1;
        dut_if.in_state = d;
        dut_if.out_ready = 1'b0;
        tick();
        sb_q.push_back(model(d));
        d = {$urandom, $urandom, $urandom, $urandom};
        dut_if.in_state = d;
        k = 0;
        while (!dut_if.out_valid && k < 50) begin tick(); k++; end
        snap = dut_if.out_state;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_out_valid", 128'(dut_if.out_valid), 128'(1));
            chk("bp_out_state", dut_if.out_state, snap);
            chk("bp_in_ready", 128'(dut_if.in_ready), 128'(0));
        end
        dut_if.out_ready = 1'b1;
        tick();
        chk("bp_handoff_valid", 128'(dut_if.out_valid), 128'(0));
        chk("bp_handoff_busy", 128'(dut_if.busy), 128'(0));
        chk("bp_keep_state", dut_if.out_state, snap);
        sb_q.push_back(model(d));
        tick();
        chk("bp_second_accept", 128'(dut_if.busy), 128'(1));
        dut_if.in_valid = 1'b0;
        finish_block(0);

        // Reset during RUN discards the block.
        wait_ready();
        dut_if.in_valid = 1'b1;
        dut_if.in_state = RT_IN;
        tick();
        dut_if.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 128'(dut_if.busy), 128'(0));
        chk("midrst_in_ready", 128'(dut_if.in_ready), 128'(1));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_valid", 128'(dut_if.out_valid), 128'(0));
        end
        send(ROW0_IN, ROW0_OUT, 0);

        sweep_go = 1'b1;
        k = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) chk("sweep_timeout", 128'(k), 128'(0));

        tick();
        chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/inv_sub_bytes_iter.md
# inv_sub_bytes_iter

Iterative inverse-SubBytes engine for the decryption datapath: it applies the FIPS-197 inverse S-box (InvSbox) to every byte of a 128-bit AES state. It processes LANES bytes per clock under a valid/ready handshake on both sides. It sits between InvShiftRows and AddRoundKey in the inverse cipher round and is the decrypt-side counterpart of the forward byte-substitution used in key expansion. One block is in flight at a time.

## Interface
- LANES, default 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (must divide 16). Derived: N = 16/LANES RUN cycles per block.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a state word on in_state.
- in_ready  output  1  engine can accept; high only in IDLE.
- in_state  input  128  input state; byte i = in_state[8i+7:8i], i = 0..15.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  substituted state, same byte mapping as in_state.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. On reset: state=IDLE, lane counter cnt=0, working register=0, out_valid=0, out_state=0, busy=0. in_ready=1 once rst is low. While rst is high, all inputs are ignored.
- IDLE: in_ready=1. Accept occurs on an edge with in_valid&in_ready. At accept: working register <= in_state, cnt <= 0, state -> RUN.
- RUN: on each edge, bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register are replaced by InvSbox(byte). Other bytes are untouched. cnt increments.
  - Edge with cnt = N-1: last lanes are substituted, cnt -> 0, state -> DONE.
  - LANES=16: exactly one RUN cycle.
- DONE: out_valid=1 and out_state = working register. Both hold stable until an edge with out_ready=1, then state -> IDLE and out_valid -> 0.
- out_state keeps its last value after the handoff. It is not cleared until the next reset.
- InvSbox is the exact inverse of the AES S-box: InvSbox(Sbox(x)) = x for all 256 x. Required spot values:
  - 63->00, 7C->01, 00->52, 01->09, ED->53, 16->FF.
- Row 0 of the table: InvSbox(00..0F) = 52 09 6A D5 30 36 A5 38 BF 40 A3 9E 81 F3 D7 FB.
- The lookup is purely combinational per lane. Any realisation (case ROM or GF(2^8) inverse plus inverse affine map) is acceptable if bit-exact.
- in_valid during RUN/DONE is not accepted (in_ready=0). Upstream must hold the word.
- out_ready while not in DONE has no effect.

## Timing
- Accept edge = edge 0. Substitution happens on edges 1..N. out_valid is high from edge N onward (LANES=4: visible 4 cycles after accept).
- DONE exit on the first edge with out_ready=1. The next accept is possible on the following edge at the earliest. Minimum block period is N+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. in_ready and busy decode from state only.
- Reset asserted mid-RUN or mid-DONE:
  - On that edge, return to IDLE and drop out_valid.
  - The partial result is discarded and never presented.
- Reset takes priority over accept and handoff on the same edge.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 -> no accept. After release: in_ready=1, out_valid=0, out_state=0, busy=0.
- Row-0 vector: in_state=128'h0F0E0D0C0B0A09080706050403020100, out_ready=1, LANES=4.
  - out_state=128'hFBD7F3819EA340BF38A53630D56A0952.
  - out_valid first high exactly 4 cycles after accept.
- Round trip: feed 128'h63636363_7C7C7C7C_EDEDEDED_16161616 -> 128'h00000000_01010101_53535353_FFFFFFFF. Then sweep all 256 S-box outputs (16 blocks) and check recovery of 0x00..0xFF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_valid and out_state are stable and in_ready=0 throughout.
  - A second in_valid is not accepted until one cycle after the handoff.
- Mid-operation reset: assert rst at RUN cycle 2 -> IDLE next edge, out_valid never rises. A subsequent block then completes correctly.
- Parameter sweep: repeat the row-0 vector with LANES=1, 2, 8, 16. The result is identical, and out_valid rises 16, 8, 2 and 1 cycles after accept respectively.
